// File: rtl/uart_mutex_arb_pkg.sv
// Shared constants, state encoding and op-word decoding for the N-node UART mutex.
package uart_mutex_pkg;

    localparam logic [15:0] START_BASE   = 16'hFBFF;
    localparam logic [15:0] STOP_WORD    = 16'hFB00;
    localparam logic [7:0]  IRQ_BYTE_DEF = 8'h4E;

    typedef enum logic {
        IDLE,
        LOCKED
    } state_t;

    // Returns the request priority (1..15), or 0 when the word is not a request.
    function automatic logic [3:0] is_request(input logic [15:0] w);
        logic [15:0] p;
        p = w ^ START_BASE;
        is_request = (p[15:4] == 12'd0) ? p[3:0] : 4'd0;
    endfunction

endpackage

// File: rtl/uart_mutex_arb_picker.sv
// Combinational arbiter: highest request priority wins, ties broken round-robin from i_rr.
module prio_rr_picker
    import uart_mutex_pkg::*;
#(
    parameter int N_NODES = 4
) (
    input  logic [16*N_NODES-1:0] i_op,
    input  logic [2:0]            i_rr,
    output logic                  o_valid,
    output logic [2:0]            o_idx
);

    localparam int IW = (N_NODES > 1) ? $clog2(N_NODES) : 1;

    logic [3:0] w_prio [N_NODES];
    logic [3:0] w_max;
    logic [3:0] w_j;
    logic       w_found;

    for (genvar g = 0; g < N_NODES; g++) begin : g_prio
        assign w_prio[g] = is_request(i_op[16*g +: 16]);
    end

    always_comb begin
        w_max   = 4'd0;
        w_j     = 4'd0;
        w_found = 1'b0;
        o_idx   = 3'd0;
        for (int i = 0; i < N_NODES; i++) begin
            if (w_prio[i] > w_max) w_max = w_prio[i];
        end
        o_valid = (w_max != 4'd0);
        // Scan cyclically starting at the round-robin pointer; first max-priority hit wins.
        for (int k = 0; k < N_NODES; k++) begin
            w_j = 4'(i_rr) + 4'(k);
            if (w_j >= 4'(N_NODES)) w_j = w_j - 4'(N_NODES);
            if (!w_found && o_valid && (w_prio[w_j[IW-1:0]] == w_max)) begin
                w_found = 1'b1;
                o_idx   = 3'(w_j);
            end
        end
    end

endmodule

// File: rtl/uart_mutex_arb.sv
// N-node UART mutex: grants the shared UART driver to one node, with IRQ-forced grant and idle watchdog.
module uart_mutex_arb
    import uart_mutex_pkg::*;
#(
    parameter int          N_NODES  = 4,
    parameter int          TIMEOUT  = 1024,
    parameter logic [7:0]  IRQ_BYTE = IRQ_BYTE_DEF
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [16*N_NODES-1:0] in_op,
    input  logic [7:0]            in_peripheral,
    input  logic                  in_irq_req,
    input  logic [2:0]            in_irq_node,
    output logic [7:0]            out_peripheral,
    output logic [15:0]           out_node,
    output logic                  rst_sig,
    output logic [N_NODES-1:0]    out_irq,
    output logic                  lock_valid,
    output logic [2:0]            lock_owner,
    output logic                  timeout_pulse
);

    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    state_t             r_state, w_nstate;
    logic [2:0]         r_owner, w_nowner;
    logic [2:0]         r_rr, w_nrr;
    logic [CW-1:0]      r_wd, w_nwd;
    logic [7:0]         r_per, w_nper;
    logic [15:0]        r_node, w_nnode;
    logic [N_NODES-1:0] r_irq, w_nirq;
    logic               r_to, w_nto;
    logic               r_rst_sig, r_lock;

    logic [15:0]        w_word;
    logic               w_irq_ok;
    logic               w_pick_vld;
    logic [2:0]         w_pick_idx;

    prio_rr_picker #(.N_NODES(N_NODES)) u_picker (
        .i_op    (in_op),
        .i_rr    (r_rr),
        .o_valid (w_pick_vld),
        .o_idx   (w_pick_idx)
    );

    assign w_word   = 16'(in_op >> (16 * r_owner));
    assign w_irq_ok = in_irq_req && (32'(in_irq_node) < N_NODES);

    always_comb begin
        w_nstate = r_state;
        w_nowner = r_owner;
        w_nrr    = r_rr;
        w_nwd    = r_wd;
        w_nper   = r_per;
        w_nnode  = r_node;
        w_nirq   = '0;
        w_nto    = 1'b0;
        case (r_state)
            IDLE: begin
                w_nper   = 8'd0;
                w_nnode  = 16'd0;
                w_nwd    = '0;
                w_nowner = 3'd0;
                if (w_irq_ok || w_pick_vld) begin
                    w_nstate = LOCKED;
                    w_nowner = w_irq_ok ? in_irq_node : w_pick_idx;
                    w_nrr    = (w_nowner == 3'(N_NODES - 1)) ? 3'd0 : w_nowner + 3'd1;
                end
            end
            LOCKED: begin
                if (w_word == STOP_WORD) begin
                    w_nstate = IDLE;
                    w_nowner = 3'd0;
                    w_nper   = 8'd0;
                    w_nnode  = 16'd0;
                    w_nwd    = '0;
                end else if (is_request(w_word) != 4'd0) begin
                    w_nper  = 8'd0;
                    w_nnode = 16'd0;
                    w_nwd   = '0;
                end else if (w_word != 16'd0) begin
                    w_nper  = w_word[7:0];
                    w_nnode = {8'(r_owner) + 8'd1, in_peripheral};
                    w_nirq  = N_NODES'(in_peripheral == IRQ_BYTE) << r_owner;
                    w_nwd   = '0;
                end else if ((TIMEOUT != 0) && (r_wd == CW'(TIMEOUT - 1))) begin
                    // Owner has been silent too long: drop the lock so others can proceed.
                    w_nstate = IDLE;
                    w_nowner = 3'd0;
                    w_nper   = 8'd0;
                    w_nnode  = 16'd0;
                    w_nwd    = '0;
                    w_nto    = 1'b1;
                end else if (r_wd != '1) begin
                    w_nwd = r_wd + 1'b1;
                end
            end
            default: w_nstate = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state   <= IDLE;
            r_owner   <= 3'd0;
            r_rr      <= 3'd0;
            r_wd      <= '0;
            r_per     <= 8'd0;
            r_node    <= 16'd0;
            r_irq     <= '0;
            r_to      <= 1'b0;
            r_rst_sig <= 1'b1;
            r_lock    <= 1'b0;
        end else begin
            r_state   <= w_nstate;
            r_owner   <= w_nowner;
            r_rr      <= w_nrr;
            r_wd      <= w_nwd;
            r_per     <= w_nper;
            r_node    <= w_nnode;
            r_irq     <= w_nirq;
            r_to      <= w_nto;
            r_rst_sig <= (w_nstate == LOCKED);
            r_lock    <= (w_nstate == LOCKED);
        end
    end

    assign out_peripheral = r_per;
    assign out_node       = r_node;
    assign rst_sig        = r_rst_sig;
    assign out_irq        = r_irq;
    assign lock_valid     = r_lock;
    assign lock_owner     = r_owner;
    assign timeout_pulse  = r_to;

endmodule
